// File: rtl/sequential_divider.sv
// -----------------------------------------------------------------------------
// sequential_divider
//
// Fixed-latency restoring (shift-subtract) divider. Divides a 2*WIDTH-bit
// dividend by a WIDTH-bit divisor and returns a 2*WIDTH-bit quotient and a
// WIDTH-bit remainder exactly 2*WIDTH clock edges after the accepting edge,
// independent of operand values (divide-by-zero included).
//
// Handshake: start is sampled only in IDLE or DONE. An accepted start
// captures both operands, clears the visible results and raises busy.
// quotientDone is a one-cycle pulse in the DONE state marking valid results,
// which then hold until the next accepted start or reset. start while busy
// is ignored.
//
// Ports
//   clk           in   1          rising-edge clock
//   rst           in   1          synchronous, active-high reset
//   start         in   1          operation request
//   dividend      in   2*WIDTH    numerator, captured on accepted start
//   divisor       in   WIDTH      denominator, captured on accepted start
//   quotient      out  2*WIDTH    result, valid from quotientDone onward
//   remainder     out  WIDTH      result, valid from quotientDone onward
//   divByZero     out  1          set with quotientDone when divisor was 0
//   busy          out  1          high while iterating
//   quotientDone  out  1          one-cycle pulse marking valid results
//   dbg_state_o   out  2          current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 divByZero,
  output logic                 busy,
  output logic                 quotientDone,
  output logic [1:0]           dbg_state_o
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       dvd_q, dvd_d;        // dividend shift register, MSB first
  logic [WIDTH-1:0]    dvd_lo_q, dvd_lo_d;  // low dividend bits for the /0 result
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic [WIDTH:0]      prem_q, prem_d;      // partial remainder, one guard bit
  logic [DW-1:0]       quo_q, quo_d;        // quotient being assembled
  logic [DW-1:0]       quot_q, quot_d;      // visible quotient
  logic [WIDTH-1:0]    rem_q, rem_d;        // visible remainder
  logic                dbz_q, dbz_d;

  // ---------------------------------------------------------------------------
  // One restoring step, evaluated every cycle and consumed only in BUSY.
  // The partial remainder is always < divisor before the shift, so after
  // shifting in one dividend bit it is < 2*divisor and fits WIDTH+1 bits;
  // after the conditional subtract it is again < divisor.
  // With divisor 0 the compare always succeeds, but the result is still
  // overridden explicitly at the final step.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]      prem_shift;
  logic                ge;
  logic [WIDTH:0]      prem_step;
  logic [DW-1:0]       quo_step;
  logic                dvs_zero;

  always_comb begin
    prem_shift = {prem_q[WIDTH-1:0], dvd_q[DW-1]};
    ge         = (prem_shift >= {1'b0, dvs_q});
    prem_step  = ge ? (prem_shift - {1'b0, dvs_q}) : prem_shift;
    quo_step   = {quo_q[DW-2:0], ge};
    dvs_zero   = (dvs_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Control flow depends only on state and counter, never
  // on operand values, so done timing is data independent.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvd_lo_d = dvd_lo_q;
    dvs_d    = dvs_q;
    prem_d   = prem_q;
    quo_d    = quo_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = BUSY;
          cnt_d    = CW'(DW);
          dvd_d    = dividend;
          dvd_lo_d = dividend[WIDTH-1:0];
          dvs_d    = divisor;
          prem_d   = '0;
          quo_d    = '0;
          quot_d   = '0;
          rem_d    = '0;
          dbz_d    = 1'b0;
        end else if (state_q == DONE) begin
          // Results keep holding in IDLE; only the done pulse ends here.
          state_d = IDLE;
        end
      end

      BUSY: begin
        dvd_d  = {dvd_q[DW-2:0], 1'b0};
        prem_d = prem_step;
        quo_d  = quo_step;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          quot_d  = dvs_zero ? {DW{1'b1}} : quo_step;
          rem_d   = dvs_zero ? dvd_lo_q   : prem_step[WIDTH-1:0];
          dbz_d   = dvs_zero;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvd_lo_q <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      quo_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvd_lo_q <= dvd_lo_d;
      dvs_q    <= dvs_d;
      prem_q   <= prem_d;
      quo_q    <= quo_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  // DONE lasts exactly one cycle (it always leaves to IDLE or BUSY), so the
  // done pulse is simply the state decode.
  assign quotient     = quot_q;
  assign remainder    = rem_q;
  assign divByZero    = dbz_q;
  assign busy         = (state_q == BUSY);
  assign quotientDone = (state_q == DONE);
  assign dbg_state_o  = state_q;

endmodule
